// File: rtl/datapath_pkg.sv
// Strobe bit positions and bus read-select codes shared by the datapath.
// No logic, so no latency and no backpressure.
package datapath_pkg;

    localparam int WE_PC     = 1;
    localparam int WE_AR     = 2;
    localparam int WE_IR     = 3;
    localparam int WE_AC     = 4;
    localparam int WE_R      = 5;
    localparam int WE_R4     = 7;
    localparam int WE_R3     = 8;
    localparam int WE_R2     = 9;
    localparam int WE_R1     = 10;
    localparam int WE_DM     = 11;
    localparam int WE_ALU_AC = 12;
    localparam int WE_AC_R   = 13;

    localparam logic [3:0] RD_NONE = 4'd0;
    localparam logic [3:0] RD_PC   = 4'd1;
    localparam logic [3:0] RD_AR   = 4'd2;
    localparam logic [3:0] RD_OPND = 4'd4;
    localparam logic [3:0] RD_AC   = 4'd5;
    localparam logic [3:0] RD_R    = 4'd6;
    localparam logic [3:0] RD_R1   = 4'd7;
    localparam logic [3:0] RD_R2   = 4'd8;
    localparam logic [3:0] RD_R3   = 4'd9;
    localparam logic [3:0] RD_R4   = 4'd10;
    localparam logic [3:0] RD_DM   = 4'd12;
    localparam logic [3:0] RD_IM   = 4'd13;

endpackage

// File: rtl/datapath_regs_reg.sv
// One datapath register: sync reset, then clear, then load, then increment.
// Updates on the next edge; there is no backpressure.
module dp_reg #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          ld,
    input  logic          inc,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q
);

    logic [DW-1:0] q_q;
    logic [DW-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr)
            q_d = '0;
        else if (ld)
            q_d = d;
        else if (inc)
            q_d = q_q + DW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            q_q <= '0;
        else
            q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/datapath_regs.sv
// Processor register file and shared bus driven by the control FSM strobes.
// Bus, addresses, opcode and z are combinational; register writes land next edge; no backpressure.
module datapath_regs
    import datapath_pkg::*;
#(
    parameter int DW  = 16,
    parameter int OPW = 6
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [15:0]    write_en,
    input  logic [15:0]    inc_en,
    input  logic [15:0]    clr_en,
    input  logic [3:0]     read_en,
    input  logic [DW-1:0]  alu_out,
    input  logic [DW-1:0]  im_rdata,
    input  logic [DW-1:0]  dm_rdata,
    output logic [DW-1:0]  bus,
    output logic [DW-1:0]  im_addr,
    output logic [DW-1:0]  dm_addr,
    output logic [DW-1:0]  dm_wdata,
    output logic           dm_we,
    output logic [DW-1:0]  ac,
    output logic [DW-1:0]  r,
    output logic [OPW-1:0] opcode,
    output logic           z
);

    logic [DW-1:0] pc, ar, ir, r1, r2, r3, r4;
    logic [DW-1:0] ac_d, r_d;
    logic          unused_strobes;

    always_comb begin
        bus = '0;
        case (read_en)
            RD_PC:   bus = pc;
            RD_AR:   bus = ar;
            RD_OPND: bus = {{OPW{1'b0}}, ir[DW-1:OPW]};
            RD_AC:   bus = ac;
            RD_R:    bus = r;
            RD_R1:   bus = r1;
            RD_R2:   bus = r2;
            RD_R3:   bus = r3;
            RD_R4:   bus = r4;
            RD_DM:   bus = dm_rdata;
            RD_IM:   bus = im_rdata;
            default: bus = '0;
        endcase
    end

    // ALU and AC->R paths outrank a bus write into the same register
    always_comb begin
        ac_d = write_en[WE_ALU_AC] ? alu_out : bus;
        r_d  = write_en[WE_AC_R]   ? ac      : bus;
    end

    dp_reg #(.DW(DW)) u_pc (.clk(clk), .rst(rst), .clr(clr_en[WE_PC]), .ld(write_en[WE_PC]),
                            .inc(inc_en[WE_PC]), .d(bus), .q(pc));
    dp_reg #(.DW(DW)) u_ar (.clk(clk), .rst(rst), .clr(clr_en[WE_AR]), .ld(write_en[WE_AR]),
                            .inc(inc_en[WE_AR]), .d(bus), .q(ar));
    dp_reg #(.DW(DW)) u_ir (.clk(clk), .rst(rst), .clr(clr_en[WE_IR]), .ld(write_en[WE_IR]),
                            .inc(inc_en[WE_IR]), .d(im_rdata), .q(ir));
    dp_reg #(.DW(DW)) u_ac (.clk(clk), .rst(rst), .clr(clr_en[WE_AC]),
                            .ld(write_en[WE_AC] | write_en[WE_ALU_AC]),
                            .inc(inc_en[WE_AC]), .d(ac_d), .q(ac));
    dp_reg #(.DW(DW)) u_r  (.clk(clk), .rst(rst), .clr(clr_en[WE_R]),
                            .ld(write_en[WE_R] | write_en[WE_AC_R]),
                            .inc(inc_en[WE_R]), .d(r_d), .q(r));
    dp_reg #(.DW(DW)) u_r1 (.clk(clk), .rst(rst), .clr(clr_en[WE_R1]), .ld(write_en[WE_R1]),
                            .inc(inc_en[WE_R1]), .d(bus), .q(r1));
    dp_reg #(.DW(DW)) u_r2 (.clk(clk), .rst(rst), .clr(clr_en[WE_R2]), .ld(write_en[WE_R2]),
                            .inc(inc_en[WE_R2]), .d(bus), .q(r2));
    dp_reg #(.DW(DW)) u_r3 (.clk(clk), .rst(rst), .clr(clr_en[WE_R3]), .ld(write_en[WE_R3]),
                            .inc(inc_en[WE_R3]), .d(bus), .q(r3));
    dp_reg #(.DW(DW)) u_r4 (.clk(clk), .rst(rst), .clr(clr_en[WE_R4]), .ld(write_en[WE_R4]),
                            .inc(inc_en[WE_R4]), .d(bus), .q(r4));

    assign im_addr  = pc;
    assign dm_addr  = ar;
    assign dm_wdata = bus;
    assign dm_we    = write_en[WE_DM];
    assign opcode   = ir[OPW-1:0];
    assign z        = (ac == '0);

    assign unused_strobes = ^{write_en[0], write_en[6], write_en[15:14],
                              inc_en[0], inc_en[6], inc_en[15:11],
                              clr_en[0], clr_en[6], clr_en[15:11]};

endmodule

// File: tb/tb_datapath_regs.sv
// Directed bench for datapath_regs with a register-array reference model.
module tb_datapath_regs;

    localparam int DW  = 16;
    localparam int OPW = 6;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [15:0]    write_en = '0, inc_en = '0, clr_en = '0;
    logic [3:0]     read_en = '0;
    logic [DW-1:0]  alu_out = '0, im_rdata = '0, dm_rdata = '0;
    logic [DW-1:0]  bus, im_addr, dm_addr, dm_wdata, ac, r;
    logic           dm_we, z;
    logic [OPW-1:0] opcode;

    int n_checks = 0;
    int n_pass   = 0;
    bit started  = 1'b0;

    // m[i] holds the register addressed by strobe bit i
    logic [DW-1:0] m [16];

    datapath_regs #(.DW(DW), .OPW(OPW)) dut (
        .clk(clk), .rst(rst), .write_en(write_en), .inc_en(inc_en), .clr_en(clr_en),
        .read_en(read_en), .alu_out(alu_out), .im_rdata(im_rdata), .dm_rdata(dm_rdata),
        .bus(bus), .im_addr(im_addr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_we(dm_we), .ac(ac), .r(r), .opcode(opcode), .z(z)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] model_bus();
        case (read_en)
            4'd1:    return m[1];
            4'd2:    return m[2];
            4'd4:    return m[3] >> OPW;
            4'd5:    return m[4];
            4'd6:    return m[5];
            4'd7:    return m[10];
            4'd8:    return m[9];
            4'd9:    return m[8];
            4'd10:   return m[7];
            4'd12:   return dm_rdata;
            4'd13:   return im_rdata;
            default: return '0;
        endcase
    endfunction

    always @(posedge clk) begin
        logic [DW-1:0] b;
        logic [DW-1:0] nxt [16];
        b = model_bus();
        for (int i = 0; i < 16; i++) begin
            nxt[i] = m[i];
            if (i == 1 || i == 2 || i == 3 || i == 4 || i == 5 || (i >= 7 && i <= 10)) begin
                if (rst)                       nxt[i] = '0;
                else if (clr_en[i])            nxt[i] = '0;
                else if (i == 4 && write_en[12]) nxt[i] = alu_out;
                else if (i == 5 && write_en[13]) nxt[i] = m[4];
                else if (write_en[i])          nxt[i] = (i == 3) ? im_rdata : b;
                else if (inc_en[i])            nxt[i] = m[i] + 16'd1;
            end
        end
        for (int i = 0; i < 16; i++) m[i] = nxt[i];
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("m_bus",     bus,       model_bus());
            chk("m_im_addr", im_addr,   m[1]);
            chk("m_dm_addr", dm_addr,   m[2]);
            chk("m_dm_wdata", dm_wdata, model_bus());
            chk("m_dm_we",   16'(dm_we), 16'(write_en[11]));
            chk("m_ac",      ac,        m[4]);
            chk("m_r",       r,         m[5]);
            chk("m_opcode",  16'(opcode), m[3] & 16'h003F);
            chk("m_z",       16'(z),    16'(m[4] == 16'd0));
        end
    end

    task automatic apply(input logic rs, input logic [15:0] we, input logic [15:0] inc,
                         input logic [15:0] clr, input logic [3:0] rd);
        @(posedge clk);
        #1;
        rst = rs; write_en = we; inc_en = inc; clr_en = clr; read_en = rd;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) m[i] = 'x;
        // reset with random strobes
        apply(1'b1, 16'($urandom), 16'($urandom), 16'($urandom), 4'd5);
        apply(1'b0, 16'h0, 16'h0, 16'h0, 4'd0);
        started = 1'b1;
        chk("rst_bus", bus, 16'h0);
        chk("rst_z", 16'(z), 16'h1);
        chk("rst_opcode", 16'(opcode), 16'h0);
        chk("rst_ac", ac, 16'h0);
        chk("rst_pc", im_addr, 16'h0);

        // fetch
        im_rdata = 16'h0283;
        apply(1'b0, 16'h1 << 3, 16'h1 << 1, 16'h0, 4'd0);
        chk("fetch_pc_old", im_addr, 16'h0);
        apply(1'b0, 16'h0, 16'h0, 16'h0, 4'd4);
        chk("fetch_opcode", 16'(opcode), 16'h0003);
        chk("fetch_pc", im_addr, 16'h0001);
        chk("fetch_operand", bus, 16'h000A);

        // jump: inc on PC is overridden by the bus load
        im_rdata = 16'h0A40;
        apply(1'b0, 16'h1 << 3, 16'h1 << 1, 16'h0, 4'd0);
        apply(1'b0, 16'h1 << 1, 16'h1 << 1, 16'h0, 4'd4);
        chk("jump_bus", bus, 16'h0029);
        apply(1'b0, 16'h0, 16'h0, 16'h0, 4'd1);
        chk("jump_pc", im_addr, 16'h0029);

        // store
        alu_out = 16'h1234; dm_rdata = 16'h0005;
        apply(1'b0, (16'h1 << 12) | (16'h1 << 2), 16'h0, 16'h0, 4'd12);
        apply(1'b0, 16'h1 << 11, 16'h0, 16'h0, 4'd5);
        chk("st_dm_we", 16'(dm_we), 16'h1);
        chk("st_dm_addr", dm_addr, 16'h0005);
        chk("st_dm_wdata", dm_wdata, 16'h1234);
        // same-cycle read/write of AC is a no-op
        apply(1'b0, 16'h1 << 4, 16'h0, 16'h0, 4'd5);
        apply(1'b0, 16'h0, 16'h0, 16'h0, 4'd0);
        chk("rw_ac", ac, 16'h1234);
        // clear beats ALU load
        alu_out = 16'hBEEF;
        apply(1'b0, 16'h1 << 12, 16'h0, 16'h1 << 4, 4'd0);
        apply(1'b0, 16'h0, 16'h0, 16'h0, 4'd0);
        chk("clr_ac", ac, 16'h0);
        chk("clr_z", 16'(z), 16'h1);

        // move and ALU path
        alu_out = 16'h0007;
        apply(1'b0, 16'h1 << 12, 16'h0, 16'h0, 4'd0);
        apply(1'b0, 16'h1 << 10, 16'h0, 16'h0, 4'd5);
        apply(1'b0, 16'h1 << 13, 16'h0, 16'h0, 4'd7);
        chk("mv_r1", bus, 16'h0007);
        alu_out = 16'h0031;
        apply(1'b0, 16'h1 << 12, 16'h0, 16'h0, 4'd7);
        chk("mv_r", r, 16'h0007);
        apply(1'b0, 16'h0, 16'h0, 16'h0, 4'd0);
        chk("alu_ac", ac, 16'h0031);
        chk("alu_z", 16'(z), 16'h0);

        // move r1 -> r3 -> r4, inc r2, then undefined read codes
        apply(1'b0, 16'h1 << 8, 16'h1 << 9, 16'h0, 4'd7);
        apply(1'b0, 16'h1 << 7, 16'h1 << 9, 16'h0, 4'd9);
        apply(1'b0, 16'h0, 16'h0, 16'h0, 4'd8);
        chk("inc_r2", bus, 16'h0002);
        apply(1'b0, 16'h0, 16'h0, 16'h0, 4'd10);
        chk("mv_r4", bus, 16'h0007);
        foreach (m[i]) begin
            if (i == 3 || i == 11 || i == 14 || i == 15) begin
                apply(1'b0, 16'h0, 16'h0, 16'h0, 4'(i));
                chk("undef_rd", bus, 16'h0);
            end
        end

        // wrap then reset mid-op
        alu_out = 16'hFFFF;
        apply(1'b0, 16'h1 << 12, 16'h0, 16'h0, 4'd0);
        apply(1'b0, 16'h0, 16'h1 << 4, 16'h0, 4'd0);
        chk("wrap_pre", ac, 16'hFFFF);
        apply(1'b1, 16'h1 << 1, 16'h0, 16'h0, 4'd5);
        chk("wrap_ac", ac, 16'h0);
        chk("wrap_z", 16'(z), 16'h1);
        apply(1'b0, 16'h0, 16'h0, 16'h0, 4'd0);
        chk("rst_mid_pc", im_addr, 16'h0);

        @(posedge clk);
        #1;
        started = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
